// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch defaults, fetch state and payload types.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Clears the byte offset so that fetch addresses are always word aligned.
  localparam logic [XLEN-1:0] WORD_ALIGN_MASK   = 32'hFFFF_FFFC;

  localparam logic [XLEN-1:0] PC_STEP           = 32'h0000_0004;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

  // One fetched slot as seen by decode.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Skid buffer between instruction memory and decode: parks the slot decode
// refused so the memory pipeline can keep its one-cycle latency.
module fetch_skid_buffer
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall_i,
  input  logic       redirect_i,
  input  fetch_pkt_t in_pkt_i,
  output fetch_pkt_t out_pkt_o
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic         w_capture;
  fetch_pkt_t   r_hold;
  fetch_pkt_t   w_sel;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: redirect wins over stall; a stall in RUN parks the live slot.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    if (redirect_i) begin
      w_state_nxt = RUN;
    end else if (r_state == RUN) begin
      if (stall_i) begin
        w_state_nxt = HOLD;
        w_capture   = 1'b1;
      end
    end else begin
      if (!stall_i) begin
        w_state_nxt = RUN;
      end
    end
  end

  // Hold registers: capture on entry to HOLD, invalidate on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold.instr <= NOP_INSTR;
      r_hold.pc    <= '0;
      r_hold.valid <= 1'b0;
    end else if (redirect_i) begin
      r_hold.valid <= 1'b0;
    end else if (w_capture) begin
      r_hold <= in_pkt_i;
    end
  end

  // Output mux; an invalid slot always presents the NOP encoding.
  always_comb begin
    w_sel     = (r_state == HOLD) ? r_hold : in_pkt_i;
    out_pkt_o = w_sel;
    if (!w_sel.valid) begin
      out_pkt_o.instr = NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, in-flight tracking for the one-cycle
// memory, and a skid buffer toward decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_instr_i,
  output logic [XLEN-1:0] id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc4_o,
  output logic            id_valid_o
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_infl_pc;
  logic            r_infl_valid;
  logic [XLEN-1:0] w_redirect_pc;
  fetch_pkt_t      w_in_pkt;
  fetch_pkt_t      w_out_pkt;

  assign w_redirect_pc = redirect_pc_i & WORD_ALIGN_MASK;
  assign imem_addr_o   = r_pc;

  // Next fetch address: redirect target, hold on stall, otherwise sequential.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_pc <= w_redirect_pc;
    end else if (!stall_i) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  // Tag the word the memory returns next cycle; a redirect kills it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_infl_pc    <= '0;
      r_infl_valid <= 1'b0;
    end else begin
      r_infl_pc    <= r_pc;
      r_infl_valid <= ~redirect_i;
    end
  end

  // Bundle the live memory slot for the skid buffer.
  always_comb begin
    w_in_pkt.instr = imem_instr_i;
    w_in_pkt.pc    = r_infl_pc;
    w_in_pkt.valid = r_infl_valid;
  end

  fetch_skid_buffer #(
    .NOP_INSTR (NOP_INSTR)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall_i),
    .redirect_i (redirect_i),
    .in_pkt_i   (w_in_pkt),
    .out_pkt_o  (w_out_pkt)
  );

  assign id_instr_o = w_out_pkt.instr;
  assign id_pc_o    = w_out_pkt.pc;
  assign id_valid_o = w_out_pkt.valid;
  assign id_pc4_o   = w_out_pkt.pc + PC_STEP;

endmodule
